// File: rtl/bypass_pkg.sv
// rtl/bypass_pkg.sv - shared types and encodings for the operand bypass network
package bypass_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int SEL_W  = 3;

  // One in-flight result tracked between EX and register-file writeback
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic              pending;
  } slot_t;

  // "No slot matched" select value: one past the oldest slot index
  function automatic logic [SEL_W-1:0] sel_none(input int depth);
    return depth[SEL_W-1:0];
  endfunction

endpackage

// File: rtl/bypass_network_if.sv
// rtl/bypass_network_if.sv - pipeline-side bus of the operand bypass network
interface bypass_network_if #(
  parameter int NSRC  = 2,
  parameter int DEPTH = 3
);
  import bypass_pkg::*;

  logic                     stall_i;
  logic                     flush_i;
  logic                     ex_valid_i;
  logic                     ex_wen_i;
  logic [REG_AW-1:0]        ex_rd_i;
  logic [XLEN-1:0]          ex_data_i;
  logic                     ex_pending_i;
  logic [XLEN-1:0]          fill_data_i;
  logic [NSRC*REG_AW-1:0]   src_addr_i;
  logic [NSRC*XLEN-1:0]     rf_data_i;
  logic [NSRC*XLEN-1:0]     fwd_data_o;
  logic [NSRC*SEL_W-1:0]    fwd_sel_o;
  logic                     hazard_o;
  logic                     wb_valid_o;
  logic [REG_AW-1:0]        wb_rd_o;
  logic [XLEN-1:0]          wb_data_o;

  // Pipeline controller side
  modport master (
    output stall_i, flush_i, ex_valid_i, ex_wen_i, ex_rd_i, ex_data_i,
           ex_pending_i, fill_data_i, src_addr_i, rf_data_i,
    input  fwd_data_o, fwd_sel_o, hazard_o, wb_valid_o, wb_rd_o, wb_data_o
  );

  // Bypass network side
  modport slave (
    input  stall_i, flush_i, ex_valid_i, ex_wen_i, ex_rd_i, ex_data_i,
           ex_pending_i, fill_data_i, src_addr_i, rf_data_i,
    output fwd_data_o, fwd_sel_o, hazard_o, wb_valid_o, wb_rd_o, wb_data_o
  );

endinterface

// File: rtl/bypass_match.sv
// rtl/bypass_match.sv - youngest-match priority search for one source operand
module bypass_match
  import bypass_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  slot_t [DEPTH-1:0] slots,
  input  logic [REG_AW-1:0] src_addr,
  input  logic [XLEN-1:0]   rf_data,
  output logic [SEL_W-1:0]  sel,
  output logic [XLEN-1:0]   data,
  output logic              pending
);

  // Scan oldest to youngest so the lowest matching index is the last to win;
  // x0 never matches because it is hardwired zero in the register file.
  always_comb begin
    sel     = sel_none(DEPTH);
    data    = rf_data;
    pending = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if ((src_addr != '0) && slots[k].valid && (slots[k].rd == src_addr)) begin
        sel     = SEL_W'(k);
        data    = slots[k].data;
        pending = slots[k].pending;
      end
    end
  end

endmodule

// File: rtl/bypass_network.sv
// rtl/bypass_network.sv - in-flight result pipeline with operand forwarding and load-use detection
module bypass_network
  import bypass_pkg::*;
#(
  parameter int NSRC  = 2,
  parameter int DEPTH = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  bypass_network_if.slave bus
);

  slot_t [DEPTH-1:0] slots_q;
  slot_t             ex_slot;
  logic [NSRC-1:0]   port_pending;

  // Incoming EX result; only register-writing instructions to x1..x31 become valid
  always_comb begin
    ex_slot.valid   = bus.ex_valid_i & bus.ex_wen_i & (bus.ex_rd_i != '0);
    ex_slot.rd      = bus.ex_rd_i;
    ex_slot.data    = bus.ex_data_i;
    ex_slot.pending = bus.ex_pending_i;
  end

  // Slot pipeline: flush kills slot 0 and wins over stall; a pending load
  // picks up its final data as it leaves slot 0, so older slots never pend.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slots_q <= '0;
    end else if (bus.flush_i) begin
      slots_q[0].valid <= 1'b0;
    end else if (!bus.stall_i) begin
      for (int k = 1; k < DEPTH; k++) begin
        slots_q[k] <= slots_q[k-1];
      end
      if (slots_q[0].pending) begin
        slots_q[1].data    <= bus.fill_data_i;
        slots_q[1].pending <= 1'b0;
      end
      slots_q[0] <= ex_slot;
    end
  end

  // One independent priority search per operand port
  for (genvar n = 0; n < NSRC; n++) begin : g_port
    bypass_match #(
      .DEPTH (DEPTH)
    ) u_match (
      .slots    (slots_q),
      .src_addr (bus.src_addr_i[n*REG_AW +: REG_AW]),
      .rf_data  (bus.rf_data_i[n*XLEN +: XLEN]),
      .sel      (bus.fwd_sel_o[n*SEL_W +: SEL_W]),
      .data     (bus.fwd_data_o[n*XLEN +: XLEN]),
      .pending  (port_pending[n])
    );
  end

  // Any operand waiting on an unfinished load stalls the consumer
  always_comb begin
    bus.hazard_o = |port_pending;
  end

  // The oldest slot is the register-file write port
  always_comb begin
    bus.wb_valid_o = slots_q[DEPTH-1].valid;
    bus.wb_rd_o    = slots_q[DEPTH-1].rd;
    bus.wb_data_o  = slots_q[DEPTH-1].data;
  end

endmodule

// File: tb/tb_bypass_network.sv
// tb/tb_bypass_network.sv - directed and randomized check of bypass_network against a queue model
module tb_bypass_network;
  import bypass_pkg::*;

  localparam int NSRC  = 2;
  localparam int DEPTH = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bypass_network_if #(.NSRC(NSRC), .DEPTH(DEPTH)) bus ();

  bypass_network #(.NSRC(NSRC), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit             v;
    bit [REG_AW-1:0] rd;
    bit [XLEN-1:0]  d;
    bit             p;
  } ent_t;

  // Index 0 is the youngest in-flight result, the back is the retiring one
  ent_t pipe[$];

  task automatic model_clear();
    ent_t z;
    z = '{v: 0, rd: 0, d: 0, p: 0};
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back(z);
  endtask

  task automatic model_clock();
    ent_t ne;
    if (bus.flush_i) begin
      pipe[0].v = 0;
    end else if (!bus.stall_i) begin
      void'(pipe.pop_back());
      if (pipe[0].p) begin
        pipe[0].d = bus.fill_data_i;
        pipe[0].p = 0;
      end
      ne.v  = bus.ex_valid_i && bus.ex_wen_i && (bus.ex_rd_i != 0);
      ne.rd = bus.ex_rd_i;
      ne.d  = bus.ex_data_i;
      ne.p  = bus.ex_pending_i;
      pipe.push_front(ne);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against what the queue model predicts
  task automatic check_all();
    bit any_haz;
    any_haz = 0;
    for (int n = 0; n < NSRC; n++) begin
      bit [REG_AW-1:0] a;
      int              sel;
      bit [XLEN-1:0]   d;
      bit              p;
      a   = bus.src_addr_i[n*REG_AW +: REG_AW];
      sel = DEPTH;
      d   = bus.rf_data_i[n*XLEN +: XLEN];
      p   = 0;
      if (a != 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (pipe[i].v && pipe[i].rd == a) begin
            sel = i;
            d   = pipe[i].d;
            p   = pipe[i].p;
            break;
          end
        end
      end
      any_haz |= p;
      check($sformatf("sel%0d", n), 32'(bus.fwd_sel_o[n*SEL_W +: SEL_W]), 32'(sel));
      if (!p) check($sformatf("data%0d", n), bus.fwd_data_o[n*XLEN +: XLEN], d);
    end
    check("hazard", 32'(bus.hazard_o), 32'(any_haz));
    check("wb_valid", 32'(bus.wb_valid_o), 32'(pipe[DEPTH-1].v));
    if (pipe[DEPTH-1].v) begin
      check("wb_rd", 32'(bus.wb_rd_o), 32'(pipe[DEPTH-1].rd));
      check("wb_data", bus.wb_data_o, pipe[DEPTH-1].d);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_clock();
    #1;
    check_all();
  endtask

  task automatic set_ex(input bit v, input bit wen, input int rd, input logic [31:0] d, input bit p);
    bus.ex_valid_i   = v;
    bus.ex_wen_i     = wen;
    bus.ex_rd_i      = REG_AW'(rd);
    bus.ex_data_i    = d;
    bus.ex_pending_i = p;
  endtask

  task automatic set_src(input int n, input int a, input logic [31:0] rf);
    bus.src_addr_i[n*REG_AW +: REG_AW] = REG_AW'(a);
    bus.rf_data_i[n*XLEN +: XLEN]      = rf;
  endtask

  function automatic logic [31:0] sel_of(input int n);
    return 32'(bus.fwd_sel_o[n*SEL_W +: SEL_W]);
  endfunction

  function automatic logic [31:0] data_of(input int n);
    return bus.fwd_data_o[n*XLEN +: XLEN];
  endfunction

  initial begin
    logic [31:0] wb_hold;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.stall_i = 0;
    bus.flush_i = 0;
    bus.fill_data_i = 0;
    bus.src_addr_i = '0;
    bus.rf_data_i = '0;
    set_ex(0, 0, 0, 0, 0);
    model_clear();
    set_src(0, 5, 32'h11);
    #12 rst = 1'b0;
    #1;
    check("rst_data", data_of(0), 32'h11);
    check("rst_sel", sel_of(0), DEPTH);
    check("rst_wbv", 32'(bus.wb_valid_o), 0);
    check("rst_wbd", bus.wb_data_o, 0);
    check("rst_haz", 32'(bus.hazard_o), 0);
    check_all();

    // Back-to-back ALU writes to x5
    set_ex(1, 1, 5, 32'hA, 0); step();
    set_ex(1, 1, 5, 32'hB, 0); step();
    check("b2b_data", data_of(0), 32'hB);
    check("b2b_sel", sel_of(0), 0);
    set_ex(0, 0, 0, 0, 0); step();
    check("b2b_s1", sel_of(0), 1);
    check("wb_a_rd", 32'(bus.wb_rd_o), 5);
    check("wb_a", bus.wb_data_o, 32'hA);
    step();
    check("wb_b", bus.wb_data_o, 32'hB);
    step();

    // Load-use on x7
    set_ex(1, 1, 7, 32'h100, 1); step();
    set_src(0, 7, 32'h77);
    #1 check("lu_haz", 32'(bus.hazard_o), 1);
    set_ex(0, 0, 0, 0, 0);
    bus.fill_data_i = 32'hDEAD;
    step();
    check("lu_sel", sel_of(0), 1);
    check("lu_data", data_of(0), 32'hDEAD);
    check("lu_nohaz", 32'(bus.hazard_o), 0);
    bus.fill_data_i = 0;
    step(); step();

    // x0 is never forwarded nor written back
    set_ex(1, 1, 0, 32'h55, 0); step();
    set_src(0, 0, 32'h0);
    set_ex(0, 0, 0, 0, 0);
    #1 check("x0_data", data_of(0), 0);
    check("x0_sel", sel_of(0), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check("x0_wbv", 32'(bus.wb_valid_o), 0);
    end

    // Stall holds x3 in slot 0, then flush with stall kills it
    set_ex(1, 1, 3, 32'h9, 0); step();
    set_src(0, 3, 32'h33);
    wb_hold = bus.wb_data_o;
    bus.stall_i = 1;
    set_ex(1, 1, 4, 32'h44, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stl_sel", sel_of(0), 0);
      check("stl_data", data_of(0), 32'h9);
      check("stl_wb", bus.wb_data_o, wb_hold);
    end
    bus.flush_i = 1; step();
    check("fl_sel", sel_of(0), DEPTH);
    check("fl_data", data_of(0), 32'h33);
    bus.flush_i = 0;
    bus.stall_i = 0;
    set_ex(0, 0, 0, 0, 0);
    step(); step(); step();

    // Dual port selects, then an asynchronous reset pulse between edges
    set_ex(1, 1, 2, 32'h22, 0); step();
    set_ex(0, 0, 0, 0, 0);      step();
    set_ex(1, 1, 1, 32'h1111, 0); step();
    set_src(0, 1, 32'hAAAA);
    set_src(1, 2, 32'hBBBB);
    set_ex(0, 0, 0, 0, 0);
    #1 check("dp_sel0", sel_of(0), 0);
    check("dp_sel1", sel_of(1), 2);
    check("dp_data1", data_of(1), 32'h22);
    check("dp_wbv", 32'(bus.wb_valid_o), 1);
    @(posedge clk); model_clock();
    #2 rst = 1'b1;
    #1;
    model_clear();
    check("ar_sel0", sel_of(0), DEPTH);
    check("ar_sel1", sel_of(1), DEPTH);
    check("ar_data1", data_of(1), 32'hBBBB);
    check("ar_wbv", 32'(bus.wb_valid_o), 0);
    check("ar_wbd", bus.wb_data_o, 0);
    #1 rst = 1'b0;
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      bus.stall_i = ($urandom_range(0, 4) == 0);
      bus.flush_i = ($urandom_range(0, 9) == 0);
      set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
             $urandom_range(0, 7), $urandom, $urandom_range(0, 3) == 0);
      bus.fill_data_i = $urandom;
      for (int n = 0; n < NSRC; n++) set_src(n, $urandom_range(0, 7), $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
